// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared types and helpers for the divider front end.
//   div_op_e          request opcode (DIV, DIVU, REM, REMU)
//   div_ctrl_state_e  sequencing states
//   is_signed/is_rem  opcode decode helpers
package div_ctrl_pkg;

    localparam int unsigned NUM_REQ  = 2;
    localparam int unsigned OP_WIDTH = 2;

    typedef enum logic [OP_WIDTH-1:0] {
        OP_DIV  = 2'd0,
        OP_DIVU = 2'd1,
        OP_REM  = 2'd2,
        OP_REMU = 2'd3
    } div_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } div_ctrl_state_e;

    function automatic logic is_signed(input div_op_e op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_rem(input div_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/div_ctrl_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
//   clk, rst_n  clock, async active-low reset
//   req[1:0]    request vector
//   en          grant enable; the pointer only moves on an enabled grant
//   gnt[1:0]    one-hot grant (combinational)
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic ptr_q;
    logic ptr_d;

    // Grant selection and pointer advance to the loser.
    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
        if (gnt[0]) begin
            ptr_d = 1'b1;
        end else if (gnt[1]) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: sequencing and sharing front end for the iterative radix-2 divider.
// Arbitrates two requesters, answers divide-by-zero, signed overflow and
// same-operand repeats from a one-entry cache without starting the divider,
// otherwise drives div_start and waits for div_ready.
//   clk, rst_n, flush                  clock, async reset, abort
//   req_valid/ready/op/a/b/tag         per-requester request port
//   rsp_valid/ready/data/tag/src       registered tagged response port
//   div_dividend/divisor/signed/start  registered divider controls
//   div_flush                          one-cycle divider abort pulse
//   div_quotient/remainder/ready       divider results
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   flush,
    input  logic [NUM_REQ-1:0]                     req_valid,
    output logic [NUM_REQ-1:0]                     req_ready,
    input  logic [NUM_REQ-1:0][OP_WIDTH-1:0]       req_op,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     req_a,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     req_b,
    input  logic [NUM_REQ-1:0][TAG_WIDTH-1:0]      req_tag,
    output logic                                   rsp_valid,
    input  logic                                   rsp_ready,
    output logic [DATA_WIDTH-1:0]                  rsp_data,
    output logic [TAG_WIDTH-1:0]                   rsp_tag,
    output logic                                   rsp_src,
    output logic [DATA_WIDTH-1:0]                  div_dividend,
    output logic [DATA_WIDTH-1:0]                  div_divisor,
    output logic                                   div_signed,
    output logic                                   div_start,
    output logic                                   div_flush,
    input  logic [DATA_WIDTH-1:0]                  div_quotient,
    input  logic [DATA_WIDTH-1:0]                  div_remainder,
    input  logic                                   div_ready
);

    localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;
    localparam logic [DATA_WIDTH-1:0] MIN_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    div_ctrl_state_e       state_q, state_d;
    div_op_e               op_q, op_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;
    logic                  src_q, src_d;
    logic                  fast_q, fast_d;
    logic [DATA_WIDTH-1:0] fast_data_q, fast_data_d;

    logic                  cache_vld_q, cache_vld_d;
    logic [DATA_WIDTH-1:0] cache_a_q, cache_a_d;
    logic [DATA_WIDTH-1:0] cache_b_q, cache_b_d;
    logic                  cache_sgn_q, cache_sgn_d;
    logic [DATA_WIDTH-1:0] cache_quo_q, cache_quo_d;
    logic [DATA_WIDTH-1:0] cache_rem_q, cache_rem_d;

    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [TAG_WIDTH-1:0]  rsp_tag_q, rsp_tag_d;
    logic                  rsp_src_q, rsp_src_d;
    logic [DATA_WIDTH-1:0] div_dividend_q, div_dividend_d;
    logic [DATA_WIDTH-1:0] div_divisor_q, div_divisor_d;
    logic                  div_signed_q, div_signed_d;
    logic                  div_start_q, div_start_d;
    logic                  div_flush_q, div_flush_d;

    logic                  arb_en;
    logic [1:0]            gnt;
    logic                  accept;
    logic                  sel;
    div_op_e               in_op;
    logic [DATA_WIDTH-1:0] in_a, in_b;
    logic [TAG_WIDTH-1:0]  in_tag;
    logic                  in_sgn, in_rem;
    logic                  in_div0, in_ovf, in_hit;
    logic [DATA_WIDTH-1:0] in_fast_data;
    logic [DATA_WIDTH-1:0] div_res;

    assign arb_en = (state_q == ST_IDLE) && !flush;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_valid),
        .en    (arb_en),
        .gnt   (gnt)
    );

    // Handshake is necessarily combinational: it depends on this cycle's flush/valid.
    assign req_ready = gnt;
    assign accept    = |gnt;
    assign sel       = gnt[1];
    assign div_res   = is_rem(op_q) ? div_remainder : div_quotient;

    // Classify the granted request: special cases and cache hits skip the divider.
    always_comb begin
        in_op   = div_op_e'(req_op[sel]);
        in_a    = req_a[sel];
        in_b    = req_b[sel];
        in_tag  = req_tag[sel];
        in_sgn  = is_signed(in_op);
        in_rem  = is_rem(in_op);
        in_div0 = (in_b == '0);
        in_ovf  = in_sgn && (in_a == MIN_NEG) && (in_b == ALL_ONES);
        in_hit  = cache_vld_q && (in_a == cache_a_q) && (in_b == cache_b_q)
                  && (in_sgn == cache_sgn_q);
        if (in_div0) begin
            in_fast_data = in_rem ? in_a : ALL_ONES;
        end else if (in_ovf) begin
            in_fast_data = in_rem ? '0 : in_a;
        end else begin
            in_fast_data = in_rem ? cache_rem_q : cache_quo_q;
        end
    end

    // Next-state and registered-output logic. Fast-path requests spend the
    // ISSUE cycle without a start pulse so their response lands one edge after accept.
    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        tag_d          = tag_q;
        src_d          = src_q;
        fast_d         = fast_q;
        fast_data_d    = fast_data_q;
        cache_vld_d    = cache_vld_q;
        cache_a_d      = cache_a_q;
        cache_b_d      = cache_b_q;
        cache_sgn_d    = cache_sgn_q;
        cache_quo_d    = cache_quo_q;
        cache_rem_d    = cache_rem_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_data_d     = rsp_data_q;
        rsp_tag_d      = rsp_tag_q;
        rsp_src_d      = rsp_src_q;
        div_dividend_d = div_dividend_q;
        div_divisor_d  = div_divisor_q;
        div_signed_d   = div_signed_q;
        div_start_d    = 1'b0;
        div_flush_d    = 1'b0;

        if (flush) begin
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b0;
            div_flush_d = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_d           = in_op;
                        tag_d          = in_tag;
                        src_d          = sel;
                        div_dividend_d = in_a;
                        div_divisor_d  = in_b;
                        fast_d         = in_div0 || in_ovf || in_hit;
                        fast_data_d    = in_fast_data;
                        if (!(in_div0 || in_ovf || in_hit)) begin
                            div_signed_d = in_sgn;
                            div_start_d  = 1'b1;
                        end
                        state_d = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (fast_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = fast_data_q;
                        rsp_tag_d   = tag_q;
                        rsp_src_d   = src_q;
                        state_d     = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (div_ready) begin
                        cache_vld_d = 1'b1;
                        cache_a_d   = div_dividend_q;
                        cache_b_d   = div_divisor_q;
                        cache_sgn_d = div_signed_q;
                        cache_quo_d = div_quotient;
                        cache_rem_d = div_remainder;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = div_res;
                        rsp_tag_d   = tag_q;
                        rsp_src_d   = src_q;
                        state_d     = ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            op_q           <= OP_DIV;
            tag_q          <= '0;
            src_q          <= 1'b0;
            fast_q         <= 1'b0;
            fast_data_q    <= '0;
            cache_vld_q    <= 1'b0;
            cache_a_q      <= '0;
            cache_b_q      <= '0;
            cache_sgn_q    <= 1'b0;
            cache_quo_q    <= '0;
            cache_rem_q    <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_data_q     <= '0;
            rsp_tag_q      <= '0;
            rsp_src_q      <= 1'b0;
            div_dividend_q <= '0;
            div_divisor_q  <= '0;
            div_signed_q   <= 1'b0;
            div_start_q    <= 1'b0;
            div_flush_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            tag_q          <= tag_d;
            src_q          <= src_d;
            fast_q         <= fast_d;
            fast_data_q    <= fast_data_d;
            cache_vld_q    <= cache_vld_d;
            cache_a_q      <= cache_a_d;
            cache_b_q      <= cache_b_d;
            cache_sgn_q    <= cache_sgn_d;
            cache_quo_q    <= cache_quo_d;
            cache_rem_q    <= cache_rem_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_data_q     <= rsp_data_d;
            rsp_tag_q      <= rsp_tag_d;
            rsp_src_q      <= rsp_src_d;
            div_dividend_q <= div_dividend_d;
            div_divisor_q  <= div_divisor_d;
            div_signed_q   <= div_signed_d;
            div_start_q    <= div_start_d;
            div_flush_q    <= div_flush_d;
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_tag      = rsp_tag_q;
    assign rsp_src      = rsp_src_q;
    assign div_dividend = div_dividend_q;
    assign div_divisor  = div_divisor_q;
    assign div_signed   = div_signed_q;
    assign div_start    = div_start_q;
    assign div_flush    = div_flush_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl with a behavioural divider alongside it.
module tb_div_ctrl;

    localparam int W = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][1:0]  req_op;
    logic [1:0][W-1:0] req_a;
    logic [1:0][W-1:0] req_b;
    logic [1:0][3:0]  req_tag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [W-1:0]     rsp_data;
    logic [3:0]       rsp_tag;
    logic             rsp_src;
    logic [W-1:0]     div_dividend, div_divisor;
    logic             div_signed, div_start, div_flush;
    logic [W-1:0]     div_quotient, div_remainder;
    logic             div_ready;

    int checks = 0;
    int failures = 0;

    // Reference state: arbitration pointer and one-entry result cache.
    int           ptr = 0;
    logic         c_vld = 1'b0;
    logic [W-1:0] c_a, c_b;
    logic         c_sgn;

    div_ctrl #(.DATA_WIDTH(W), .TAG_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_tag(rsp_tag), .rsp_src(rsp_src),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_signed(div_signed), .div_start(div_start), .div_flush(div_flush),
        .div_quotient(div_quotient), .div_remainder(div_remainder),
        .div_ready(div_ready)
    );

    always #5 clk = ~clk;

    // RISC-V division semantics computed with 64-bit arithmetic.
    function automatic logic [W-1:0] ref_res(input logic [1:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        longint sa, sb, q, r;
        logic   sgn;
        sgn = (op == 2'd0) || (op == 2'd2);
        if (b == '0) return op[1] ? a : '1;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return op[1] ? r[W-1:0] : q[W-1:0];
    endfunction

    // Behavioural radix-2 divider: loads on start, ready again W edges later.
    int           dv_cnt;
    logic         dv_busy;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dv_busy       <= 1'b0;
            dv_cnt        <= 0;
            div_ready     <= 1'b1;
            div_quotient  <= '0;
            div_remainder <= '0;
        end else if (div_flush) begin
            dv_busy   <= 1'b0;
            div_ready <= 1'b1;
        end else if (div_start) begin
            dv_busy       <= 1'b1;
            dv_cnt        <= W;
            div_ready     <= 1'b0;
            div_quotient  <= ref_res(div_signed ? 2'd0 : 2'd1, div_dividend, div_divisor);
            div_remainder <= ref_res(div_signed ? 2'd2 : 2'd3, div_dividend, div_divisor);
        end else if (dv_busy) begin
            dv_cnt <= dv_cnt - 1;
            if (dv_cnt == 1) begin
                dv_busy   <= 1'b0;
                div_ready <= 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Expected latency from the cache model; divider completions refill it.
    task automatic predict(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           output int lat);
        logic sgn, fast;
        sgn  = (op == 2'd0) || (op == 2'd2);
        fast = (b == '0) || (sgn && a == 32'h8000_0000 && b == '1)
               || (c_vld && c_a == a && c_b == b && c_sgn == sgn);
        if (!fast) begin
            c_vld = 1'b1;
            c_a   = a;
            c_b   = b;
            c_sgn = sgn;
        end
        lat = fast ? 1 : W + 2;
    endtask

    // Wait for a grant (called just after inputs change), check it, step past the accept edge.
    task automatic accept(output int g);
        int n, exp_g;
        n = 0;
        #1;
        while (req_ready == 2'b00 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("accept_wait", 64'(n < 100), 64'd1);
        exp_g = (req_valid == 2'b11) ? ptr : (req_valid[1] ? 1 : 0);
        check("grant", 64'(req_ready), (exp_g == 1) ? 64'd2 : 64'd1);
        ptr = 1 - exp_g;
        g   = exp_g;
        @(posedge clk);
        #1;
    endtask

    // Called just after the accept edge; measures latency and checks the response.
    task automatic wait_rsp(input logic [W-1:0] exp_data, input int exp_lat,
                            input logic [3:0] exp_tag, input int exp_src, input int hold);
        int   lat, starts;
        logic got;
        starts = int'(div_start);
        lat    = 0;
        got    = 1'b0;
        while (!got && lat < 60) begin
            @(posedge clk);
            lat++;
            #1;
            if (rsp_valid) got = 1'b1;
            else starts += int'(div_start);
        end
        check("rsp_latency", 64'(lat), 64'(exp_lat));
        check("rsp_data", 64'(rsp_data), 64'(exp_data));
        check("rsp_tag", 64'(rsp_tag), 64'(exp_tag));
        check("rsp_src", 64'(rsp_src), 64'(exp_src));
        check("div_start_pulses", 64'(starts), (exp_lat == 1) ? 64'd0 : 64'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            req_valid = 2'b11;
            #1;
            check("rsp_hold", {rsp_valid, rsp_data, rsp_tag, req_ready},
                  {1'b1, exp_data, exp_tag, 2'b00});
        end
        @(negedge clk);
        if (hold > 0) req_valid = 2'b00;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("rsp_released", 64'(rsp_valid), 64'd0);
    endtask

    task automatic run_req(input int src, input logic [1:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [3:0] tag,
                           input logic [W-1:0] exp_data, input int hold);
        int g, lat;
        @(negedge clk);
        req_valid      = 2'b00;
        req_valid[src] = 1'b1;
        req_op[src]    = op;
        req_a[src]     = a;
        req_b[src]     = b;
        req_tag[src]   = tag;
        accept(g);
        req_valid = 2'b00;
        predict(op, a, b, lat);
        wait_rsp(exp_data, lat, tag, src, hold);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]   aop [2][4];
        logic [W-1:0] aa [2][4];
        logic [W-1:0] ab [2][4];
        logic [3:0]   atag [2][4];
        int           idx [2];
        int           g, lat, sel;
        logic [1:0]   op;
        logic [W-1:0] a, b, prev_a, prev_b;
        logic         seen;

        rst_n = 1'b0; flush = 1'b0; rsp_ready = 1'b0;
        req_valid = '0; req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
        prev_a = 32'd100; prev_b = 32'd7;
        repeat (2) @(negedge clk);
        check("reset_outputs", {req_ready, rsp_valid, rsp_tag, rsp_src, div_signed,
                                div_start, div_flush}, 64'd0);
        check("reset_data", {rsp_data, div_dividend}, 64'd0);
        check("reset_divisor", 64'(div_divisor), 64'd0);
        rst_n = 1'b1;

        // Directed: divider path then cache hit; special cases.
        run_req(0, 2'd1, 32'd100, 32'd7, 4'h5, 32'd14, 0);
        run_req(0, 2'd3, 32'd100, 32'd7, 4'h6, 32'd2, 0);
        run_req(1, 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 4'h7, 32'h8000_0000, 0);
        run_req(1, 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 4'h8, 32'h0, 0);
        run_req(0, 2'd0, 32'hFFFF_FFF9, 32'd2, 4'h9, 32'hFFFF_FFFD, 0);
        run_req(1, 2'd2, 32'hFFFF_FFF9, 32'd2, 4'hA, 32'hFFFF_FFFF, 0);
        run_req(0, 2'd1, 32'd5, 32'd0, 4'hB, 32'hFFFF_FFFF, 0);
        run_req(1, 2'd3, 32'd5, 32'd0, 4'hC, 32'd5, 0);

        // Response back-pressure for 10 cycles.
        run_req(0, 2'd1, 32'd1000, 32'd10, 4'h3, 32'd100, 10);

        // Both requesters continuously valid: grants alternate.
        for (int s = 0; s < 2; s++) begin
            idx[s] = 0;
            for (int k = 0; k < 4; k++) begin
                aop[s][k]  = 2'($urandom_range(0, 3));
                aa[s][k]   = $urandom;
                ab[s][k]   = 32'($urandom_range(1, 5000));
                atag[s][k] = 4'($urandom);
            end
        end
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                req_valid[s] = (idx[s] < 4);
                if (idx[s] < 4) begin
                    req_op[s]  = aop[s][idx[s]];
                    req_a[s]   = aa[s][idx[s]];
                    req_b[s]   = ab[s][idx[s]];
                    req_tag[s] = atag[s][idx[s]];
                end
            end
            accept(g);
            predict(aop[g][idx[g]], aa[g][idx[g]], ab[g][idx[g]], lat);
            wait_rsp(ref_res(aop[g][idx[g]], aa[g][idx[g]], ab[g][idx[g]]), lat,
                     atag[g][idx[g]], g, 0);
            idx[g]++;
        end
        req_valid = 2'b00;

        // Randomized requests, biased toward special cases and repeats.
        for (int i = 0; i < 16; i++) begin
            sel = $urandom_range(0, 5);
            op  = 2'($urandom_range(0, 3));
            a   = $urandom;
            b   = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            if (sel == 0) b = '0;
            if (sel == 1) begin a = 32'h8000_0000; b = '1; end
            if (sel == 2) begin a = prev_a; b = prev_b; end
            prev_a = a;
            prev_b = b;
            run_req($urandom_range(0, 1), op, a, b, 4'($urandom), ref_res(op, a, b), 0);
        end

        // Flush during WAIT.
        @(negedge clk);
        req_valid = 2'b01; req_op[0] = 2'd1; req_a[0] = 32'd123456; req_b[0] = 32'd789;
        req_tag[0] = 4'h1;
        accept(g);
        req_valid = 2'b00;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_pulse", {div_flush, rsp_valid}, 64'd2);
        @(posedge clk);
        #1;
        check("flush_single", 64'(div_flush), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            seen |= rsp_valid;
        end
        check("no_rsp_after_flush", 64'(seen), 64'd0);
        run_req(0, 2'd1, 32'd9, 32'd3, 4'h2, 32'd3, 0);

        // Reset in the middle of WAIT.
        @(negedge clk);
        req_valid = 2'b10; req_op[1] = 2'd1; req_a[1] = 32'd1000; req_b[1] = 32'd3;
        req_tag[1] = 4'hF;
        accept(g);
        req_valid = 2'b00;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midop_reset_outputs", {req_ready, rsp_valid, rsp_tag, rsp_src, div_signed,
                                      div_start, div_flush}, 64'd0);
        check("midop_reset_data", {rsp_data, div_dividend}, 64'd0);
        check("midop_reset_divisor", 64'(div_divisor), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        c_vld = 1'b0;
        ptr   = 0;
        run_req(0, 2'd3, 32'd100, 32'd7, 4'h4, 32'd2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Sequencing and sharing front end for the iterative radix-2 divider (`div`). It arbitrates DIV/DIVU/REM/REMU requests from two requesters, such as two issue ports, using round-robin. It resolves RISC-V special cases (divide-by-zero, signed overflow) and same-operand back-to-back pairs (DIV then REM) in one cycle without starting the divider. It drives the divider's start/flush and returns one tagged result per request over a valid/ready response port.

## Interface
- `DATA_WIDTH`, 32, operand/result width; must match the attached divider.
- `TAG_WIDTH`, 4, opaque requester tag, returned unchanged.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `flush`  in  1  abort the in-flight operation and any pending response.
- `req_valid`  in  [1:0]  per-requester request valid.
- `req_ready`  out  [1:0]  per-requester accept; at most one bit high.
- `req_op`  in  [1:0][1:0]  op: 0 DIV, 1 DIVU, 2 REM, 3 REMU.
- `req_a`, `req_b`  in  [1:0][DATA_WIDTH-1:0]  dividend, divisor.
- `req_tag`  in  [1:0][TAG_WIDTH-1:0]  tag.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_data`  out  DATA_WIDTH  quotient (DIV/DIVU) or remainder (REM/REMU).
- `rsp_tag`  out  TAG_WIDTH  tag of the request.
- `rsp_src`  out  1  index of the requester that owns the result.
- `div_dividend`, `div_divisor`  out  DATA_WIDTH  registered divider operands.
- `div_signed`  out  1  divider `signed_ope`.
- `div_start`  out  1  one-cycle divider start pulse.
- `div_flush`  out  1  one-cycle divider flush pulse.
- `div_quotient`, `div_remainder`  in  DATA_WIDTH  divider results.
- `div_ready`  in  1  divider idle / result valid.

## Operation
- States: IDLE, ISSUE, WAIT, RESP. Reset enters IDLE.
- Reset values of all outputs: `req_ready` 0, `rsp_valid` 0, `rsp_data`/`rsp_tag`/`rsp_src` 0, `div_*` 0.
- `req_ready` is nonzero only in IDLE with `flush`=0.
- Arbitration:
  - The grant goes to the single valid requester.
  - When both are valid, the grant goes to the requester the priority pointer selects.
  - The pointer (reset 0) moves to the non-granted requester after every grant.
- Accept (IDLE handshake): register op, a, b, tag and source, then classify the request.
  - Divide-by-zero (b==0): DIV/DIVU → all ones; REM/REMU → a. Go to RESP.
  - Signed overflow (DIV/REM, a==1<<(W-1), b==all ones): DIV → a; REM → 0. Go to RESP.
  - Cache hit: cache valid, a/b equal to cached, signedness equal. Select quotient or remainder per op. Go to RESP.
  - Otherwise go to ISSUE.
- ISSUE: assert `div_start` for one cycle with registered operands and `div_signed`=op∈{DIV,REM}. Go to WAIT.
- WAIT: on `div_ready`=1:
  - Capture the quotient or remainder per op.
  - Load the cache with a, b, signedness, quotient and remainder, and set cache valid.
  - Go to RESP.
- RESP: hold `rsp_valid`=1 and the response fields stable until `rsp_ready`, then go to IDLE.
- Cache:
  - Single entry; valid reset 0.
  - Survives `flush`.
  - Written only by divider completions, never by special cases.
- Flush:
  - From any state, go to IDLE next cycle and drop the request or response.
  - `div_flush` pulses for one cycle if the state was ISSUE or WAIT.
  - Flush has priority over a simultaneous accept, completion or response handshake.
- Reset mid-operation: immediate return to reset values. The divider is reset by the shared `rst_n`.

## Timing
- Accept edge E0.
- Fast path (special case or cache hit): `rsp_valid` high from E1.
- Divider path:
  - `div_start` high in the cycle after E0; the divider loads at E1.
  - `div_ready` returns high after E(W+1).
  - The result is captured at E(W+2), so `rsp_valid` is high from E(W+2). That is E34 at W=32.
- WAIT never samples `div_ready` in the ISSUE cycle; the divider's `ready` is still high then.
- Throughput: one request in flight. The next accept is no earlier than the cycle after the response handshake.
- Response fields are registered; no combinational path from `req_*` to `rsp_*`.

## Structure
- `div_ctrl_pkg`: `div_op_e` (DIV, DIVU, REM, REMU), `div_ctrl_state_e`, `is_signed(op)`, `is_rem(op)`.
- Sub-module `rr_arb2`: two-way round-robin arbiter with a pointer, `req[1:0]`, `en` and `gnt[1:0]` one-hot.
- The top instantiates `div_ctrl` and `div` side by side; `div_ctrl` does not instantiate `div`.

## Test plan
- DIVU 100/7 from requester 0 → `div_start` one pulse; `rsp_data`=14 with `rsp_valid` at E34; tag echoed. Then REMU 100/7 → 2 at E1 with no `div_start` (cache hit).
- DIV 0x80000000/0xFFFFFFFF → 0x80000000 at E1; REM same operands → 0. DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF.
- DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; both at E1, no `div_start`.
- Both requesters valid continuously with 4 ops each → grants alternate 0,1,0,1,…; `rsp_src` matches each grant.
- `rsp_ready` held low 10 cycles in RESP → `rsp_valid` and data stable, `req_ready`=00 throughout.
- `flush` in WAIT cycle 10 → `div_flush` pulse, no response, IDLE next cycle. A following DIVU 9/3 → 3 at E34. `rst_n` low mid-WAIT → all outputs at reset values.
